// File: rtl/jt49_wr_seq.sv
// jt49_wr_seq -- timed register-write sequencer for jt49 PSGs.
//
// Plays a script of {delay, chip, addr, data} entries from an internal
// synchronous-read RAM. For each entry, it waits 'delay' cen ticks and then
// issues a STRB-cycle active-low write strobe on wr_n and on the selected
// cs_n bit. The script is loaded through load_* while the sequencer is idle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cen             delay timebase enable (one tick per high cycle)
//   load_we/addr/data  script RAM write port, entry = {delay, chip, addr, data}
//   last            index of the final entry played
//   start           begin playback at entry 0 (ignored while busy)
//   loop            at end of sequence: 1 restarts at entry 0
//   pause           freezes the delay countdown
//   abort           returns to idle at once, cutting any strobe
//   cs_n, wr_n      per-chip select and write strobe, active low
//   addr, din       register address / data, stable around the strobe
//   busy, eof, ptr  status: running, end-of-sequence pulse, current entry
module jt49_wr_seq #(
   parameter int CHIPS = 1,
   parameter int AW    = 4,
   parameter int DW    = 8,
   parameter int DLYW  = 16,
   parameter int DEPTH = 256,
   parameter int STRB  = 2,
   localparam int PW   = $clog2(DEPTH),
   localparam int CSW  = (CHIPS > 1) ? $clog2(CHIPS) : 1,
   localparam int EW   = DLYW + CSW + AW + DW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             load_we,
   input  logic [PW-1:0]    load_addr,
   input  logic [EW-1:0]    load_data,
   input  logic [PW-1:0]    last,
   input  logic             start,
   input  logic             loop,
   input  logic             pause,
   input  logic             abort,
   output logic [CHIPS-1:0] cs_n,
   output logic             wr_n,
   output logic [AW-1:0]    addr,
   output logic [DW-1:0]    din,
   output logic             busy,
   output logic             eof,
   output logic [PW-1:0]    ptr
);

   localparam int SW = (STRB > 1) ? $clog2(STRB) : 1;
   localparam logic [CSW:0] CHIPS_LIM = (CSW + 1)'(CHIPS);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, WAIT, STROBE, NEXT
   } state_t;

   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] rd_data_d, rd_data_q;

   state_t           state_d, state_q;
   logic [PW-1:0]    ptr_d, ptr_q;
   logic [DLYW-1:0]  cnt_d, cnt_q;
   logic [AW-1:0]    addr_d, addr_q;
   logic [DW-1:0]    din_d, din_q;
   logic [CSW-1:0]   sel_d, sel_q;
   logic [SW-1:0]    scnt_d, scnt_q;
   logic [CHIPS-1:0] cs_n_d, cs_n_q;
   logic             wr_n_d, wr_n_q;
   logic             busy_d, busy_q;
   logic             eof_d, eof_q;
   logic             fin_d, fin_q;

   logic [DLYW-1:0] ent_dly;
   logic [CSW-1:0]  ent_chip;
   logic [AW-1:0]   ent_addr;
   logic [DW-1:0]   ent_data;
   logic            chip_ok;

   assign ent_dly  = rd_data_q[EW-1 -: DLYW];
   assign ent_chip = rd_data_q[AW+DW +: CSW];
   assign ent_addr = rd_data_q[DW +: AW];
   assign ent_data = rd_data_q[DW-1:0];

   // Chip indices beyond CHIPS select nothing; the strobe slot is still spent.
   assign chip_ok = ({1'b0, sel_q} < CHIPS_LIM);

   // The read address is ptr, which is stable through FETCH, so rd_data_q
   // holds entry[ptr] by DECODE.
   always_comb begin
      rd_data_d = mem[ptr_q];
   end

   always_ff @(posedge clk) begin
      if (load_we && state_q == IDLE) begin
         mem[load_addr] <= load_data;
      end
      rd_data_q <= rd_data_d;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      din_d   = din_q;
      sel_d   = sel_q;
      scnt_d  = scnt_q;
      cs_n_d  = cs_n_q;
      wr_n_d  = wr_n_q;
      busy_d  = busy_q;
      eof_d   = 1'b0;
      fin_d   = fin_q;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               ptr_d   = '0;
               busy_d  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = DECODE;
         end
         DECODE: begin
            cnt_d   = ent_dly;
            addr_d  = ent_addr;
            din_d   = ent_data;
            sel_d   = ent_chip;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               // Strobe lines are registered, so they are driven low on the
               // edge that enters STROBE.
               scnt_d  = SW'(STRB - 1);
               state_d = STROBE;
               if (chip_ok) begin
                  wr_n_d = 1'b0;
                  for (int i = 0; i < CHIPS; i++) begin
                     cs_n_d[i] = (sel_q != CSW'(i));
                  end
               end
            end else if (cen && !pause) begin
               cnt_d = cnt_q - DLYW'(1);
            end
         end
         STROBE: begin
            if (scnt_q == '0) begin
               wr_n_d  = 1'b1;
               cs_n_d  = '1;
               state_d = NEXT;
               // End-of-sequence is decided here so that eof and the busy
               // fall are visible during the NEXT cycle itself.
               if (ptr_q == last && !loop) begin
                  eof_d  = 1'b1;
                  busy_d = 1'b0;
                  fin_d  = 1'b1;
               end else begin
                  fin_d  = 1'b0;
               end
            end else begin
               scnt_d = scnt_q - SW'(1);
            end
         end
         NEXT: begin
            if (fin_q) begin
               fin_d   = 1'b0;
               state_d = IDLE;
            end else begin
               ptr_d   = (ptr_q != last) ? ptr_q + PW'(1) : '0;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // abort overrides everything outside IDLE; addr, din and ptr are kept.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         cs_n_d  = '1;
         wr_n_d  = 1'b1;
         busy_d  = 1'b0;
         eof_d   = 1'b0;
         fin_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         sel_q   <= '0;
         scnt_q  <= '0;
         cs_n_q  <= '1;
         wr_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         eof_q   <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         sel_q   <= sel_d;
         scnt_q  <= scnt_d;
         cs_n_q  <= cs_n_d;
         wr_n_q  <= wr_n_d;
         busy_q  <= busy_d;
         eof_q   <= eof_d;
         fin_q   <= fin_d;
      end
   end

   assign cs_n = cs_n_q;
   assign wr_n = wr_n_q;
   assign addr = addr_q;
   assign din  = din_q;
   assign busy = busy_q;
   assign eof  = eof_q;
   assign ptr  = ptr_q;

endmodule
